// File: rtl/button_conditioner_pkg.sv
// Shared button definitions: press/hold FSM state encodings, default timing
// for a 50 MHz board, and a small helper used to size the hold counter.
// No ports (package).
package button_conditioner_pkg;

  // Press/hold FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Default timing at 50 MHz: 0.4 ms debounce, 200 ms repeat delay, 50 ms period
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd20000;
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd10000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 32'd2500000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_conditioner_sync_debounce.sv
// sync_debounce: 2-FF synchroniser followed by a persistence filter.
// A new synchronised level is accepted only after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   i_clk     system clock (rising edge)
//   i_rst     synchronous active-high reset
//   i_button  raw asynchronous button level
//   o_level   debounced level, 1 = pressed (polarity normalised), registered
//   o_toggle  high in the cycle whose rising edge will flip o_level; lets a
//             downstream stage register an event aligned with the new level
module sync_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_toggle
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 32'd1);
  // Count value at which one more mismatching cycle reaches DEBOUNCE_CYCLES
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample_s;
  logic          mismatch_s;
  logic          toggle_s;

  // Next-state logic for synchroniser and debounce counter
  always_comb begin
    sync1_d    = i_button;
    sync2_d    = sync1_q;
    sample_s   = sync2_q ^ ACTIVE_LOW;
    mismatch_s = (sample_s != level_q);
    toggle_s   = mismatch_s && (cnt_q == CNT_LAST);
    if (!mismatch_s) begin
      // Any agreeing cycle restarts the persistence count
      cnt_d   = '0;
      level_d = level_q;
    end else if (toggle_s) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      level_d = level_q;
    end
  end

  // State registers; sync flops reset to the idle raw level so reset never
  // looks like a press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level  = level_q;
  assign o_toggle = toggle_s;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns the raw count-up push-button into clean
// single-cycle events for the display counter (o_pulse is its increment
// enable), with optional auto-repeat while the button is held.
// Ports:
//   i_clk       system clock (rising edge)
//   i_rst       synchronous active-high reset
//   i_button    raw asynchronous button level
//   o_pressed   debounced level, 1 = pressed
//   o_pulse     one-cycle strobe per accepted press and per repeat
//   o_released  one-cycle strobe on accepted release
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_pressed,
  output logic o_pulse,
  output logic o_released
);

  localparam int unsigned    HOLD_SPAN   = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned    HW          = $clog2(HOLD_SPAN + 32'd1);
  // Tick fires on the edge where the count would reach the target value
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 32'd1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 32'd1);
  localparam logic [HW-1:0] HOLD_SAT    = '1;

  logic          level_s;
  logic          toggle_s;
  logic          press_evt_s;
  logic          release_evt_s;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pulse_q, pulse_d;
  logic          released_q, released_d;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_sync_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_button (i_button),
    .o_level  (level_s),
    .o_toggle (toggle_s)
  );

  // Press/release decoded from the debounced level about to flip, so the
  // registered strobes line up with the first cycle of the new level
  assign press_evt_s   = toggle_s & ~level_s;
  assign release_evt_s = toggle_s &  level_s;

  // Press/hold/repeat FSM next-state and strobe generation
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pulse_d    = 1'b0;
    released_d = 1'b0;
    if (release_evt_s) begin
      // Release outranks a coincident repeat tick
      state_d    = ST_IDLE;
      hold_d     = '0;
      released_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_evt_s) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            pulse_d = 1'b1;
          end else begin
            hold_d = '0;
          end
        end
        ST_HOLD: begin
          if (REPEAT_EN) begin
            if (hold_q == DELAY_LAST) begin
              state_d = ST_REPEAT;
              hold_d  = '0;
              pulse_d = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + HW'(1);
          end else begin
            hold_d = hold_q;
          end
        end
        ST_REPEAT: begin
          if (hold_q == PERIOD_LAST) begin
            hold_d  = '0;
            pulse_d = 1'b1;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // FSM state, hold counter and output strobe registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      pulse_q    <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pulse_q    <= pulse_d;
      released_q <= released_d;
    end
  end

  assign o_pressed  = level_s;
  assign o_pulse    = pulse_q;
  assign o_released = released_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw push-button input (the count-up button, idle-high) into clean single-cycle events for the display counter.
- Pipeline: 2-FF synchroniser, then a debounce filter, then a press/hold FSM with optional auto-repeat.
- Sits directly upstream of the counter/7-segment driver. `o_pulse` is the counter's increment enable.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive cycles a new synchronised level must persist before it is accepted (≥1).
- ACTIVE_LOW, 1: 1 means raw button reads 0 when pressed.
- REPEAT_EN, 1: enables auto-repeat while held.
- REPEAT_DELAY, 10000000: cycles from accepted press to first repeat pulse (≥1).
- REPEAT_PERIOD, 2500000: cycles between subsequent repeat pulses (≥1).

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_button  in  1  raw asynchronous button level
- o_pressed  out  1  debounced level, 1 = pressed (polarity normalised)
- o_pulse  out  1  one-cycle strobe per accepted press and per repeat
- o_released  out  1  one-cycle strobe on accepted release

Behaviour:
- **Reset.** One clock and one reset. i_rst is synchronous and active-high, sampled on the i_clk rising edge. While i_rst is high:
  - both sync flops load the idle raw level (1 if ACTIVE_LOW, else 0);
  - the debounce counter, hold counter and all outputs go to 0;
  - the FSM goes to IDLE.
  - Reset mid-press: the first cycle after reset sees a stable "released" state. A still-held button is then accepted as a new press after the normal latency.
- **Synchroniser.** sync1 <= i_button; sync2 <= sync1. Normalised sample s = sync2 XOR ACTIVE_LOW.
- **Debounce.**
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If s == o_pressed, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, o_pressed toggles and the counter clears.
  - Any mismatch-free cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES are fully rejected.
  - Latency: o_pressed changes exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw level.
- **FSM states.** IDLE, HOLD, REPEAT. The hold counter has width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - **IDLE:**
    - On an accepted press (o_pressed 0→1 this edge): go to HOLD, clear the hold counter, and assert o_pulse in the same cycle o_pressed first reads 1.
  - **HOLD:**
    - The hold counter increments each cycle.
    - When REPEAT_EN=1 and the count reaches REPEAT_DELAY: o_pulse=1, go to REPEAT, clear the counter.
    - When REPEAT_EN=0: the counter saturates and no further pulses occur.
  - **REPEAT:**
    - o_pulse=1 every REPEAT_PERIOD cycles; the counter clears on each pulse.
  - **Any state:**
    - On an accepted release (o_pressed 1→0): go to IDLE, o_released=1 for one cycle, counter cleared.
  - **Simultaneous events:** a release and a repeat tick in the same cycle means release wins and o_pulse stays 0.
- **Output rules.**
  - o_pulse and o_released are never high in the same cycle.
  - Each is high for exactly one cycle per event.
  - All outputs are registered; no combinational path from i_button.

Decomposition:
- Shared package/header button_defs:
  - FSM state encodings ST_IDLE=2'd0, ST_HOLD=2'd1, ST_REPEAT=2'd2.
  - Default timing constants for a 50 MHz board (debounce 0.4 ms, repeat delay 200 ms, period 50 ms).
- One sub-module, sync_debounce:
  - Holds the synchroniser and debounce counter.
  - Parameters DEBOUNCE_CYCLES, ACTIVE_LOW; outputs o_level.
  - Reused for the reset button later.
- The FSM and repeat counter live in button_conditioner.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW=1; i_button idle 1):
- **Reset:** hold i_rst=1 for 3 cycles with i_button=0 → o_pressed=o_pulse=o_released=0 throughout. After release, o_pressed rises 6 cycles later with one o_pulse.
- **Clean press:** drive i_button=0 for 10 cycles → o_pressed rises 6 edges after the drop, one o_pulse in that cycle. On return to 1, o_released pulses 6 edges later.
- **Bounce rejection:** toggle i_button 0/1 every 2 cycles for 20 cycles, then leave it at 1 → o_pressed stays 0, no o_pulse.
- **Auto-repeat:** hold i_button=0 for 60 cycles after acceptance → o_pulse at acceptance, +20, +28, +36, +44, +52 (6 pulses total).
- **Release vs repeat collision:** time the accepted release to land exactly on the +20 tick → o_released=1, o_pulse=0, FSM returns to IDLE.
- **REPEAT_EN=0:** hold for 100 cycles → exactly one o_pulse; hold counter saturates without wrap.
